serial_adder: RTL and testbench

- Bit-serial adder. Accepts two WIDTH-bit operands on a start strobe and adds them LSB-first, one bit per clock, through a single registered-carry full-adder cell (two half-adder stages plus OR).
- Emits each sum bit as it is produced, then presents the full parallel sum and carry-out with a one-cycle done pulse.
- Sits downstream of operand-sourcing logic and replaces a WIDTH-wide ripple adder where area matters more than latency.

---
 rtl/serial_adder_if.sv | 26 ++
 rtl/serial_adder.sv | 128 ++++++++++++
 tb/tb_serial_adder.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/serial_adder_if.sv
// Operand/result bundle for the bit-serial adder.
// Handshake: the master holds start with a/b; the slave accepts them on a
// rising clk edge where start=1 and ready=1. Results (sum, carry) are valid
// while done=1, and sum_bit is valid whenever sum_bit_valid=1.
interface serial_adder_if #(parameter int WIDTH = 8);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             ready;
  logic             busy;
  logic             sum_bit;
  logic             sum_bit_valid;
  logic [WIDTH-1:0] sum;
  logic             carry;
  logic             done;

  modport master (
    output start, a, b,
    input  ready, busy, sum_bit, sum_bit_valid, sum, carry, done
  );

  modport slave (
    input  start, a, b,
    output ready, busy, sum_bit, sum_bit_valid, sum, carry, done
  );
endinterface

// File: rtl/serial_adder.sv
// Bit-serial adder: one full-adder cell with a registered carry, LSB first.
// An accepted start spends WIDTH cycles in RUN (one sum bit each), then a
// single DONE cycle presents sum/carry with done=1. DONE also accepts start
// so additions can run back-to-back.
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  serial_adder_if.slave      bus,
  output logic [1:0]         dbg_state
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             c_q, c_d;
  logic             carry_q, carry_d;
  logic             sbit_q, sbit_d;
  logic             sval_q, sval_d;
  logic             done_q, done_d;

  // Full adder built from two half-adder stages plus an OR.
  logic ha1_s, ha1_c, ha2_s, ha2_c, fa_c;
  assign ha1_s = a_q[0] ^ b_q[0];
  assign ha1_c = a_q[0] & b_q[0];
  assign ha2_s = ha1_s ^ c_q;
  assign ha2_c = ha1_s & c_q;
  assign fa_c  = ha1_c | ha2_c;

  logic last_bit;
  assign last_bit = (cnt_q == CW'(WIDTH - 1));

  // Next-state, datapath and registered-output computation.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    sum_d   = sum_q;
    cnt_d   = cnt_q;
    c_d     = c_q;
    carry_d = carry_q;
    sbit_d  = sbit_q;
    sval_d  = 1'b0;
    done_d  = 1'b0;
    case (state_q)
      IDLE, DONE: begin
        if (bus.start) begin
          a_d     = bus.a;
          b_d     = bus.b;
          res_d   = '0;
          cnt_d   = '0;
          c_d     = 1'b0;
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        sbit_d = ha2_s;
        sval_d = 1'b1;
        res_d  = {ha2_s, res_q[WIDTH-1:1]};
        a_d    = a_q >> 1;
        b_d    = b_q >> 1;
        c_d    = fa_c;
        cnt_d  = cnt_q + CW'(1);
        if (last_bit) begin
          sum_d   = {ha2_s, res_q[WIDTH-1:1]};
          carry_d = fa_c;
          done_d  = 1'b1;
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset discards any run in progress.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      sum_q   <= '0;
      cnt_q   <= '0;
      c_q     <= 1'b0;
      carry_q <= 1'b0;
      sbit_q  <= 1'b0;
      sval_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      sum_q   <= sum_d;
      cnt_q   <= cnt_d;
      c_q     <= c_d;
      carry_q <= carry_d;
      sbit_q  <= sbit_d;
      sval_q  <= sval_d;
      done_q  <= done_d;
    end
  end

  assign bus.ready         = (state_q == IDLE) || (state_q == DONE);
  assign bus.busy          = (state_q == RUN);
  assign bus.sum_bit       = sbit_q;
  assign bus.sum_bit_valid = sval_q;
  assign bus.sum           = sum_q;
  assign bus.carry         = carry_q;
  assign bus.done          = done_q;
  assign dbg_state         = state_q;

endmodule

// File: tb/tb_serial_adder.sv
// Directed and random checks for serial_adder (WIDTH=8).
module tb_serial_adder;

  localparam int W = 8;

  logic       clk;
  logic       rst;
  logic [1:0] dbg_state;

  serial_adder_if #(.WIDTH(W)) bus ();

  serial_adder #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [W-1:0] exp_q[$];

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] sum;
    logic         carry;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Advance one edge, settle 1ns after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Starts an addition from a ready state and follows it to its DONE cycle.
  // Leaves the DUT in DONE (done=1) on return. If poke is set, a start with
  // different operands is attempted while busy and must be ignored.
  task automatic run_add(input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] esum, input logic ecarry,
                         input bit poke);
    logic [W-1:0] bits;
    logic [W-1:0] exp_bit;
    bits = '0;
    for (int i = 0; i < W; i++) exp_q.push_back(W'(esum[i]));
    chk("ready_before_start", {31'd0, bus.ready}, 32'd1);
    bus.start = 1'b1;
    bus.a = a;
    bus.b = b;
    step();
    bus.start = 1'b0;
    bus.a = ~a;
    bus.b = ~b;
    chk("busy_after_accept", {30'd0, bus.busy, bus.ready}, 32'd2);
    for (int i = 0; i < W; i++) begin
      if (poke && i == 1) begin
        bus.start = 1'b1;
        bus.a = 8'h01;
        bus.b = 8'h01;
      end
      if (poke && i == W - 2) bus.start = 1'b0;
      step();
      chk("bit_valid", {31'd0, bus.sum_bit_valid}, 32'd1);
      chk("done_timing", {31'd0, bus.done}, (i == W - 1) ? 32'd1 : 32'd0);
      exp_bit = exp_q.pop_front();
      chk("serial_bit", {31'd0, bus.sum_bit}, {24'd0, exp_bit});
      bits[i] = bus.sum_bit;
    end
    chk("sum", {24'd0, bus.sum}, {24'd0, esum});
    chk("carry", {31'd0, bus.carry}, {31'd0, ecarry});
    chk("reassembled", {24'd0, bits}, {24'd0, esum});
    chk("ready_in_done", {30'd0, bus.ready, bus.busy}, 32'd2);
  endtask

  logic [W:0] tot;
  logic [W-1:0] ra, rb;

  initial begin
    vecs[0] = '{8'h00, 8'h00, 8'h00, 1'b0};
    vecs[1] = '{8'hFF, 8'h01, 8'h00, 1'b1};
    vecs[2] = '{8'h0F, 8'h01, 8'h10, 1'b0};
    vecs[3] = '{8'hFF, 8'hFF, 8'hFE, 1'b1};
    vecs[4] = '{8'h12, 8'h34, 8'h46, 1'b0};
    vecs[5] = '{8'hC3, 8'h7D, 8'h40, 1'b1};
    vecs[6] = '{8'h55, 8'h2A, 8'h7F, 1'b0};

    bus.start = 1'b0;
    bus.a = '0;
    bus.b = '0;
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    chk("rst_ready", {31'd0, bus.ready}, 32'd1);
    chk("rst_busy", {31'd0, bus.busy}, 32'd0);
    chk("rst_sum", {24'd0, bus.sum}, 32'd0);
    chk("rst_carry", {31'd0, bus.carry}, 32'd0);
    chk("rst_done", {31'd0, bus.done}, 32'd0);
    chk("rst_valid", {30'd0, bus.sum_bit_valid, bus.sum_bit}, 32'd0);
    chk("rst_state", {30'd0, dbg_state}, 32'd0);

    // Table vectors, each followed by an idle gap.
    for (int v = 0; v < 7; v++) begin
      run_add(vecs[v].a, vecs[v].b, vecs[v].sum, vecs[v].carry, 1'b0);
      step();
      chk("done_one_cycle", {31'd0, bus.done}, 32'd0);
      chk("idle_no_valid", {31'd0, bus.sum_bit_valid}, 32'd0);
      chk("idle_state", {30'd0, dbg_state}, 32'd0);
      chk("sum_held", {24'd0, bus.sum}, {24'd0, vecs[v].sum});
      chk("sum_bit_held", {31'd0, bus.sum_bit}, {31'd0, vecs[v].sum[W-1]});
    end

    // Start during busy is ignored.
    run_add(8'hA5, 8'h5A, 8'hFF, 1'b0, 1'b1);
    step();
    chk("poke_idle", {30'd0, dbg_state}, 32'd0);
    chk("poke_sum_kept", {24'd0, bus.sum}, 32'h0FF);

    // Back-to-back: new start in the DONE cycle, no IDLE between.
    run_add(8'h33, 8'h44, 8'h77, 1'b0, 1'b0);
    run_add(8'h80, 8'h80, 8'h00, 1'b1, 1'b0);
    step();

    // Reset on the 4th RUN cycle aborts the run.
    bus.start = 1'b1;
    bus.a = 8'h0F;
    bus.b = 8'h01;
    step();
    bus.start = 1'b0;
    step();
    step();
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("abort_ready", {30'd0, bus.ready, bus.busy}, 32'd2);
    chk("abort_sum", {24'd0, bus.sum}, 32'd0);
    chk("abort_carry", {31'd0, bus.carry}, 32'd0);
    for (int i = 0; i < W + 2; i++) begin
      chk("abort_no_done", {31'd0, bus.done}, 32'd0);
      chk("abort_no_valid", {31'd0, bus.sum_bit_valid}, 32'd0);
      step();
    end
    run_add(8'h0F, 8'h01, 8'h10, 1'b0, 1'b0);
    step();

    // Random sweep, mixing idle gaps and back-to-back starts.
    for (int n = 0; n < 200; n++) begin
      ra = W'($urandom_range(0, 255));
      rb = W'($urandom_range(0, 255));
      if (n == 0) begin
        ra = 8'hFF;
        rb = 8'hFF;
      end
      tot = {1'b0, ra} + {1'b0, rb};
      run_add(ra, rb, tot[W-1:0], tot[W], 1'b0);
      if ($urandom_range(0, 1) == 1) step();
    end
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
